// File: rtl/pipe_pkg.sv
// Shared constants for pipe_stage_reg: state encoding and counter widths.
package pipe_pkg;
  localparam int OCC_W      = 2;
  localparam int PERF_CNT_W = 32;

  localparam logic [OCC_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [OCC_W-1:0] ST_BUSY  = 2'd1;
  localparam logic [OCC_W-1:0] ST_FULL  = 2'd2;
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Width-parametrised saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with 2-entry skid buffer, freeze and flush.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter bit                FLUSH_ZERO = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [OCC_W-1:0]      occupancy,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] bubble_cnt
);
  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge; valid never depends on ready of the same side.
  logic [OCC_W-1:0]  state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              emit;

  assign in_ready  = (state_q != ST_FULL) & ~freeze & ~flush & ~rst;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready & ~freeze;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (FLUSH_ZERO) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            main_d  = in_data;
          end
        end
        ST_BUSY: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain of main can happen
          if (emit) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_inc;
  logic bubble_inc;

  assign stall_inc  = out_valid & ~emit & ~flush;
  assign bubble_inc = ~out_valid;

  sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(PERF_CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (bubble_inc),
    .cnt   (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule
